// File: rtl/mdu_divider.sv
// mdu_divider: multi-cycle radix-2 restoring divider serving DIV (signed) and DIVU (unsigned).
// Optional macro DIV_EARLY_ZERO_EN: a zero divisor skips the iteration and completes in two cycles.
module mdu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_div,
   input  logic             start_divu,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             busy_div,
   output logic             busy_divu,
   output logic             over,
   output logic             over_div,
   output logic             over_divu,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             signed_op;
   logic             sq, sr, zero;
   logic [WIDTH-1:0] dvsr, quo, rem, dvd_raw;
   logic [WIDTH:0]   rem_shift, rem_diff;
   logic             start;

   function automatic logic [WIDTH-1:0] neg_wrap(input logic [WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? neg_wrap(v) : v;
   endfunction

   always_comb begin
      start     = start_div | start_divu;
      rem_shift = {rem, quo[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, dvsr};
   end

   // Datapath: operand capture and one restoring step per CALC cycle; quo doubles as dividend shifter.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (start) begin
            dvd_raw <= dividend;
            zero    <= (divisor == '0);
            rem     <= '0;
            if (start_div) begin
               quo  <= mag(dividend);
               dvsr <= mag(divisor);
               sq   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sr   <= dividend[WIDTH-1];
            end else begin
               quo  <= dividend;
               dvsr <= divisor;
               sq   <= 1'b0;
               sr   <= 1'b0;
            end
         end
         CALC: begin
            if (!rem_diff[WIDTH]) begin
               rem <= rem_diff[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
               rem <= rem_shift[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b0};
            end
         end
         default: ;
      endcase
   end

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         signed_op <= 1'b0;
         busy_div  <= 1'b0;
         busy_divu <= 1'b0;
         over_div  <= 1'b0;
         over_divu <= 1'b0;
         q         <= '0;
         r         <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               over_div  <= 1'b0;
               over_divu <= 1'b0;
               if (start) begin
                  signed_op <= start_div;
                  busy_div  <= start_div;
                  busy_divu <= ~start_div;
                  count     <= '0;
`ifdef DIV_EARLY_ZERO_EN
                  // FIX already forces the zero-divisor results, so the iteration can be bypassed.
                  state     <= (divisor == '0) ? FIX : CALC;
`else
                  state     <= CALC;
`endif
               end
            end
            CALC: begin
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               busy_div  <= 1'b0;
               busy_divu <= 1'b0;
               over_div  <= signed_op;
               over_divu <= ~signed_op;
               div_zero  <= zero;
               if (zero) begin
                  q <= '1;
                  r <= dvd_raw;
               end else begin
                  q <= sq ? neg_wrap(quo) : quo;
                  r <= sr ? neg_wrap(rem) : rem;
               end
               state <= DONE;
            end
            DONE: begin
               over_div  <= 1'b0;
               over_divu <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = busy_div | busy_divu;
   assign over = over_div | over_divu;

endmodule
